peripheral_showresult: RTL
==========================

Name: peripheral_showresult

Overview:
- Downstream display stage for the operand-entry path.
- Captures the 32-bit value produced from dataA/dataB (operands or ALU result) on a load strobe.
- Drives a time-multiplexed 4-digit active-low 7-segment display, 16 bits (4 hex digits) at a time.
- A raw push-button pages between the low half and the high half of the captured value.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot. Legal range ≥1; 1 = advance every cycle.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- result_i  input  32  value to display
- load_i  input  1  one-cycle strobe; capture result_i
- pagebutton_i  input  1  raw, asynchronous page button (active-high)
- an_o  output  4  digit enables, active-low; an_o[0] = rightmost digit
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  output  1  decimal point, active-low
- page_o  output  1  current page: 0 = bits[15:0], 1 = bits[31:16]
- valid_o  output  1  a value has been captured since reset

Behaviour:
- Reset (reset=0, asynchronous, regardless of clk):
  - held register = 0, valid_o=0, page_o=0, scan index=0, divider=0, sync flops=0.
  - an_o=4'b1111, seg_o=7'h7F, dp_o=1.
- Load: if load_i=1 at a clk edge: held <= result_i, valid_o <= 1, page_o <= 0.
- Button path:
  - pagebutton_i passes through a 2-flop synchronizer, then a rising-edge detector (previous-sample flop).
  - Each detected rising edge toggles page_o. A held button gives exactly one toggle.
  - Edge reaches page_o 3 cycles after the input transition.
- Simultaneous load_i and detected edge in the same cycle: load wins, page_o=0.
- Divider:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick=1 in the cycle the count equals REFRESH_DIV-1.
  - On tick, scan index <= (index+1) mod 4, so 3 wraps to 0.
- Output registers (updated every clk from the current index; 1-cycle lag after an index change):
  - an_o <= ~(4'b0001 << index).
  - Nibble for digit k = held[page*16 + 4k +: 4].
  - seg_o <= hex decode of that nibble when valid_o=1; 7'h3F (dash, g only) when valid_o=0.
  - dp_o <= 0 when index=3 and page_o=1, else 1.
- Hex decode (seg_o):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Reset asserted mid-scan: all outputs go to their reset values immediately. After release, scanning restarts at digit 0 with full divider period.
- New load during scanning: the change is visible from the next output register update. The scan position is not disturbed.

Test Plan (REFRESH_DIV=4 unless stated):
- Reset held, then released, no load -> during reset an_o=1111, seg_o=7F, dp_o=1, valid_o=0. After release seg_o=3F, an_o cycles 1110→1101→1011→0111→1110, 4 clks per digit.
- load_i with result_i=32'h1234ABCD -> valid_o=1, page_o=0. Digits 0..3 show seg_o 21,46,03,08; dp_o=1 throughout.
- After that load, pulse pagebutton_i high for 10 clks -> page_o=1 exactly 3 clks after the rise, a single toggle. Digits 0..3 show 19,30,24,79; dp_o=0 only while an_o=0111.
- Second button press, then load_i coincident with a detected edge carrying 32'hFFFF0000 -> page_o=0, digits show 40,40,40,40. Next press -> page_o=1, digits show 0E on all four.
- Assert reset while an_o=1011 -> outputs return to their reset values without a clk edge. After release the first enabled digit is an_o=1110.
- REFRESH_DIV=1, load 32'h00008421 -> index advances every cycle. an_o/seg_o pairs: 1110/79, 1101/24, 1011/19, 0111/00, repeating.

Source files
------------

// File: rtl/peripheral_showresult.sv
// Display stage: holds a 32-bit value and scans 4 hex digits of the selected half
// onto an active-low, time-multiplexed 7-segment display; a push-button pages halves.
module peripheral_showresult #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] result_i,
  input  logic        load_i,
  input  logic        pagebutton_i,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic        page_o,
  output logic        valid_o
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [31:0]      r_held;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;

  logic             w_edge;
  logic             w_tick;
  logic [15:0]      w_half;
  logic [3:0]       w_digit [4];
  logic [3:0]       w_nib;
  logic [6:0]       w_seg_hex;

  assign w_edge = r_sync2 & ~r_prev;
  assign w_tick = (r_div == DIV_LAST);
  assign w_half = page_o ? r_held[31:16] : r_held[15:0];

  // digit 0 is the least significant nibble of the shown half (rightmost position)
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign w_digit[gi] = w_half[4*gi +: 4];
    end
  endgenerate

  assign w_nib = w_digit[r_idx];

  always_comb begin
    w_seg_hex = 7'h7F;
    case (w_nib)
      4'h0: w_seg_hex = 7'h40;
      4'h1: w_seg_hex = 7'h79;
      4'h2: w_seg_hex = 7'h24;
      4'h3: w_seg_hex = 7'h30;
      4'h4: w_seg_hex = 7'h19;
      4'h5: w_seg_hex = 7'h12;
      4'h6: w_seg_hex = 7'h02;
      4'h7: w_seg_hex = 7'h78;
      4'h8: w_seg_hex = 7'h00;
      4'h9: w_seg_hex = 7'h10;
      4'hA: w_seg_hex = 7'h08;
      4'hB: w_seg_hex = 7'h03;
      4'hC: w_seg_hex = 7'h46;
      4'hD: w_seg_hex = 7'h21;
      4'hE: w_seg_hex = 7'h06;
      4'hF: w_seg_hex = 7'h0E;
      default: w_seg_hex = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_held  <= '0;
      r_div   <= '0;
      r_idx   <= 2'd0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      valid_o <= 1'b0;
      page_o  <= 1'b0;
      an_o    <= 4'b1111;
      seg_o   <= 7'h7F;
      dp_o    <= 1'b1;
    end else begin
      r_sync1 <= pagebutton_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;

      if (w_tick) begin
        r_div <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_div <= r_div + 1'b1;
      end

      // a load always returns to the low half, even if a button edge lands in the same cycle
      if (load_i) begin
        r_held  <= result_i;
        valid_o <= 1'b1;
        page_o  <= 1'b0;
      end else if (w_edge) begin
        page_o <= ~page_o;
      end

      an_o  <= ~(4'b0001 << r_idx);
      seg_o <= valid_o ? w_seg_hex : 7'h3F;
      dp_o  <= ~((r_idx == 2'd3) & page_o);
    end
  end

endmodule
